apb_slave_regfile: RTL and testbench

APB slave register file that sits directly downstream of the team's APB master and terminates its PSEL/PENABLE transfers. It provides a word-addressed bank of 32-bit control registers with byte strobes, a parameterised number of wait states per transfer, and PSLVERR on illegal accesses. It also exposes a read-only ID register and a live hardware status register, and drives the register contents plus per-register write pulses to the rest of the design.

---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_slave_wait_ctrl.sv | 65 ++++++
 rtl/apb_slave_regfile.sv | 143 ++++++++++++++
 tb/tb_apb_slave_regfile.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types, register indices and access-error decode for the APB register file.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int unsigned REG_ID_IDX     = 0;
  localparam int unsigned REG_STATUS_IDX = 1;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA0B0_0001;

  // Misaligned, beyond the bank, or a write to one of the read-only words.
  function automatic logic decode_err(input logic [31:0] addr, input logic write,
                                      input int unsigned num_regs);
    logic [31:0] idx;
    idx = addr >> 2;
    return (addr[1:0] != 2'b00) || (idx >= num_regs) ||
           (write && (idx <= 32'(REG_STATUS_IDX)));
  endfunction

endpackage

// File: rtl/apb_slave_wait_ctrl.sv
// Transfer sequencing for the APB slave: setup detection, wait-state count,
// PREADY generation and abort on PSEL loss.
module apb_slave_wait_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic psel,
  input  logic penable,
  output logic ready,
  output logic setup_go,
  output logic ready_set,
  output logic commit,
  output logic abort
);

  apb_state_e state_reg;
  logic [3:0] cnt_reg;

  // Strobes describe what the coming clock edge will do.
  assign setup_go  = (state_reg == IDLE) && psel && !penable;
  assign abort     = (state_reg == ACCESS) && !psel;
  assign commit    = (state_reg == ACCESS) && ready && psel && penable;
  assign ready_set = (setup_go && (WAIT_CYCLES == 0)) ||
                     ((state_reg == ACCESS) && psel && !ready && (cnt_reg == 4'd1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      ready     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (setup_go) begin
            state_reg <= ACCESS;
            cnt_reg   <= 4'(WAIT_CYCLES);
            ready     <= (WAIT_CYCLES == 0);
          end
        end
        ACCESS: begin
          if (!psel) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            ready     <= 1'b0;
          end else if (ready) begin
            if (penable) begin
              state_reg <= IDLE;
              ready     <= 1'b0;
            end
          end else if (cnt_reg > 4'd1) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else if (cnt_reg == 4'd1) begin
            cnt_reg <= 4'd0;
            ready   <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave register bank: ID and live STATUS words, byte-strobed RW control
// registers, configurable wait states and PSLVERR on illegal accesses.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = DATA_WIDTH'(DEFAULT_ID_VALUE)
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  input  logic [DATA_WIDTH-1:0]          hw_status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_regs_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned NB    = DATA_WIDTH / 8;

  logic                  setup_go, ready_set, commit, abort;
  logic [IDX_W-1:0]      idx_reg;
  logic                  write_reg, err_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [NB-1:0]         strb_reg;
  logic                  setup_err;
  logic [IDX_W-1:0]      idx_sel;
  logic                  write_sel, err_sel;
  logic [DATA_WIDTH-1:0] rd_next;
  logic [DATA_WIDTH-1:0] prdata_reg;
  logic                  pslverr_reg;
  logic [DATA_WIDTH-1:0] reg_img [NUM_REGS];

  apb_slave_wait_ctrl #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_ctrl (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .psel     (PSEL),
    .penable  (PENABLE),
    .ready    (PREADY),
    .setup_go (setup_go),
    .ready_set(ready_set),
    .commit   (commit),
    .abort    (abort)
  );

  assign setup_err = decode_err(32'(PADDR), PWRITE, NUM_REGS);

  // Everything used later in the transfer is frozen at setup.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      idx_reg   <= '0;
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
      wdata_reg <= '0;
      strb_reg  <= '0;
    end else if (setup_go) begin
      idx_reg   <= PADDR[ADDR_WIDTH-1:2];
      write_reg <= PWRITE;
      err_reg   <= setup_err;
      wdata_reg <= PWDATA;
      strb_reg  <= PSTRB;
    end
  end

  // With zero wait states the response is built on the setup edge itself,
  // before the latched copies exist.
  assign idx_sel   = setup_go ? PADDR[ADDR_WIDTH-1:2] : idx_reg;
  assign write_sel = setup_go ? PWRITE : write_reg;
  assign err_sel   = setup_go ? setup_err : err_reg;

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_sel == IDX_W'(i)) rd_next = reg_img[i];
    end
    if (idx_sel == IDX_W'(REG_STATUS_IDX)) rd_next = hw_status_in;
    if (err_sel || write_sel) rd_next = '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prdata_reg  <= '0;
      pslverr_reg <= 1'b0;
    end else if (abort || commit) begin
      prdata_reg  <= '0;
      pslverr_reg <= 1'b0;
    end else if (ready_set) begin
      prdata_reg  <= rd_next;
      pslverr_reg <= err_sel;
    end
  end

  assign PRDATA  = prdata_reg;
  assign PSLVERR = pslverr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == REG_ID_IDX) begin : g_id
        assign reg_img[gi]  = ID_VALUE;
        assign wr_pulse[gi] = 1'b0;
      end else if (gi == REG_STATUS_IDX) begin : g_status
        assign reg_img[gi]  = '0;
        assign wr_pulse[gi] = 1'b0;
      end else begin : g_rw
        logic [DATA_WIDTH-1:0] data_reg;
        logic                  pulse_reg;
        logic                  hit;

        assign hit = commit && write_reg && !err_reg && (idx_reg == IDX_W'(gi));

        always_ff @(posedge PCLK or negedge PRESETn) begin
          if (!PRESETn) begin
            data_reg  <= '0;
            pulse_reg <= 1'b0;
          end else begin
            pulse_reg <= hit && (strb_reg != '0);
            for (int b = 0; b < NB; b++) begin
              if (hit && strb_reg[b]) data_reg[8*b +: 8] <= wdata_reg[8*b +: 8];
            end
          end
        end

        assign reg_img[gi]  = data_reg;
        assign wr_pulse[gi] = pulse_reg;
      end
      assign ctrl_regs_out[gi*DATA_WIDTH +: DATA_WIDTH] = reg_img[gi];
    end
  endgenerate

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed and randomized checks of apb_slave_regfile with 2 and 0 wait states.
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA0B0_0001;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [7:0]  PADDR;
  logic        PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] hw_status;
  logic        psel_a, psel_b;

  logic [31:0]  prdata_a, prdata_b;
  logic         pready_a, pready_b, pslverr_a, pslverr_b;
  logic [511:0] ctrl_a, ctrl_b;
  logic [15:0]  pulse_a, pulse_b;

  bit           cur;
  logic [31:0]  prdata_m;
  logic         pready_m, pslverr_m;
  logic [15:0]  pulse_m;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model [2][16];
  int          exp_wait [2] = '{2, 0};
  logic [31:0] rd;

  always #5 PCLK = ~PCLK;

  assign prdata_m  = cur ? prdata_b  : prdata_a;
  assign pready_m  = cur ? pready_b  : pready_a;
  assign pslverr_m = cur ? pslverr_b : pslverr_a;
  assign pulse_m   = cur ? pulse_b   : pulse_a;

  apb_slave_regfile #(.WAIT_CYCLES(2)) u_w2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(psel_a), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata_a), .PREADY(pready_a),
    .PSLVERR(pslverr_a), .hw_status_in(hw_status), .ctrl_regs_out(ctrl_a), .wr_pulse(pulse_a)
  );

  apb_slave_regfile #(.WAIT_CYCLES(0)) u_w0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(psel_b), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata_b), .PREADY(pready_b),
    .PSLVERR(pslverr_b), .hw_status_in(hw_status), .ctrl_regs_out(ctrl_b), .wr_pulse(pulse_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
  endtask

  function automatic logic [31:0] slot_exp(input bit d, input int i);
    if (i == 0) return ID;
    if (i == 1) return 32'h0;
    return model[d][i];
  endfunction

  function automatic logic [31:0] slot_of(input bit d, input int i);
    return d ? ctrl_b[i*32 +: 32] : ctrl_a[i*32 +: 32];
  endfunction

  task automatic check_image(input bit d);
    for (int i = 0; i < 16; i++)
      check($sformatf("dut%0d_slot%0d", d, i), slot_of(d, i), slot_exp(d, i));
  endtask

  // One complete APB transfer; keep=1 leaves PSEL high for a back-to-back setup.
  task automatic op(input bit d, input bit wr, input logic [7:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input bit keep, output logic [31:0] rdata);
    int          idx;
    int          waits;
    bit          e;
    logic [31:0] exp_rd;
    logic [15:0] exp_pulse;
    idx = int'(addr) / 4;
    e = (addr % 4 != 0) || (idx >= 16) || (wr && idx < 2);
    exp_rd = 32'h0;
    exp_pulse = 16'h0;
    if (!e && !wr) exp_rd = (idx == 0) ? ID : (idx == 1) ? hw_status : model[d][idx];
    if (!e && wr && strb != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[d][idx][8*b +: 8] = data[8*b +: 8];
      exp_pulse = 16'h1 << idx;
    end
    cur = d;
    PADDR = addr; PWRITE = wr; PWDATA = data; PSTRB = strb; PENABLE = 1'b0;
    psel_a = (d == 1'b0);
    psel_b = (d == 1'b1);
    check("setup_pready", 32'(pready_m), 32'h0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    // Garble the bus during the access phase; the slave must use setup values.
    PADDR = $urandom; PWDATA = $urandom; PWRITE = $urandom; PSTRB = $urandom;
    waits = 0;
    while (pready_m !== 1'b1 && waits < 40) begin
      @(posedge PCLK); #1;
      waits++;
    end
    check("wait_cycles", 32'(waits), 32'(exp_wait[d]));
    check("pslverr", 32'(pslverr_m), 32'(e));
    check("prdata", prdata_m, exp_rd);
    check("pulse_early", 32'(pulse_m), 32'h0);
    rdata = prdata_m;
    @(posedge PCLK); #1;
    check("pready_one_cycle", 32'(pready_m), 32'h0);
    check("wr_pulse", 32'(pulse_m), 32'(exp_pulse));
    $display("[TB] dut%0d %s addr=%02h data=%08h strb=%h -> prdata=%08h err=%0d waits=%0d",
             d, wr ? "WR" : "RD", addr, data, strb, rdata, e, waits);
    PENABLE = 1'b0;
    if (!keep) begin
      psel_a = 1'b0;
      psel_b = 1'b0;
    end
  endtask

  initial begin
    psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h0; PWDATA = 32'h0; PSTRB = 4'h0; hw_status = 32'h5A5A_0000; cur = 1'b0;
    reset_model();
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_pready", 32'(pready_a), 32'h0);
    check("rst_pslverr", 32'(pslverr_a), 32'h0);
    check("rst_prdata", prdata_a, 32'h0);
    check("rst_pulse", 32'(pulse_a), 32'h0);
    check("rst_pready_w0", 32'(pready_b), 32'h0);
    check_image(1'b0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Full and partial writes, then readback of the merged word.
    op(1'b0, 1'b1, 8'h08, 32'h1234_5678, 4'hF, 1'b0, rd);
    check("slot2_full", slot_of(1'b0, 2), 32'h1234_5678);
    op(1'b0, 1'b1, 8'h08, 32'hAABB_CCDD, 4'b0101, 1'b0, rd);
    op(1'b0, 1'b0, 8'h08, 32'h0, 4'h0, 1'b0, rd);
    check("merge_read", rd, 32'h12BB_56DD);
    op(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, rd);
    check("id_read", rd, ID);
    op(1'b0, 1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
    op(1'b0, 1'b0, 8'h41, 32'h0, 4'h0, 1'b0, rd);
    op(1'b0, 1'b0, 8'h40, 32'h0, 4'h0, 1'b0, rd);
    hw_status = 32'hDEAD_BEEF;
    op(1'b0, 1'b0, 8'h04, 32'h0, 4'h0, 1'b0, rd);
    check("status_read", rd, 32'hDEAD_BEEF);
    op(1'b0, 1'b1, 8'h0C, 32'h9999_9999, 4'h0, 1'b0, rd);
    check_image(1'b0);

    // Zero wait states, back-to-back writes.
    op(1'b1, 1'b1, 8'h08, 32'h1111_2222, 4'hF, 1'b1, rd);
    op(1'b1, 1'b1, 8'h0C, 32'h3333_4444, 4'hF, 1'b0, rd);
    check("b2b_slot2", slot_of(1'b1, 2), 32'h1111_2222);
    check("b2b_slot3", slot_of(1'b1, 3), 32'h3333_4444);

    // Stray PENABLE with no setup phase.
    cur = 1'b0; psel_a = 1'b1; PENABLE = 1'b1; PADDR = 8'h08; PWRITE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge PCLK); #1;
      check("stray_pready", 32'(pready_a), 32'h0);
    end
    psel_a = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;

    // Abort: PSEL dropped in the first access cycle of a write.
    PADDR = 8'h10; PWRITE = 1'b1; PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF; psel_a = 1'b1;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; psel_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge PCLK); #1;
      check("abort_pready", 32'(pready_a), 32'h0);
      check("abort_pulse", 32'(pulse_a), 32'h0);
    end
    PENABLE = 1'b0;
    check("abort_slot4", slot_of(1'b0, 4), model[0][4]);
    op(1'b0, 1'b1, 8'h10, 32'h0BAD_F00D, 4'hF, 1'b0, rd);
    check("after_abort_slot4", slot_of(1'b0, 4), 32'h0BAD_F00D);

    // Reset during a wait state of a write.
    PADDR = 8'h08; PWRITE = 1'b1; PWDATA = 32'hCAFE_F00D; PSTRB = 4'hF; psel_a = 1'b1;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    #1;
    reset_model();
    check("mid_rst_pready", 32'(pready_a), 32'h0);
    check("mid_rst_prdata", prdata_a, 32'h0);
    check("mid_rst_slot2", slot_of(1'b0, 2), 32'h0);
    check("mid_rst_w0_slot3", slot_of(1'b1, 3), 32'h0);
    psel_a = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    op(1'b0, 1'b0, 8'h08, 32'h0, 4'h0, 1'b0, rd);
    check("post_rst_read", rd, 32'h0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      bit          d, wr, keep;
      int          idx;
      logic [7:0]  addr;
      idx = $urandom_range(0, 17);
      addr = 8'(idx * 4);
      if ($urandom_range(0, 7) == 0) addr = addr + 8'($urandom_range(1, 3));
      d = 1'($urandom);
      wr = 1'($urandom);
      keep = 1'($urandom);
      hw_status = $urandom;
      op(d, wr, addr, $urandom, 4'($urandom), keep, rd);
    end
    psel_a = 1'b0; psel_b = 1'b0;
    @(posedge PCLK); #1;
    check_image(1'b0);
    check_image(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
